// File: rtl/seg_scan_driver_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_driver_pkg
//  Description : Shared constants, types and helpers for the multiplexed
//                seven-segment scan driver.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_scan_driver_pkg;

    localparam int          DIGITS  = 6;
    localparam logic [7:0]  SEG_OFF = 8'hFF;
    localparam logic [5:0]  AN_OFF  = 6'h3F;

    // Defaults derive from the same 1 MHz base that produces the 1 s tick.
    localparam int SYS_CLK_HZ       = 1_000_000;
    localparam int DEF_SCAN_DIV     = SYS_CLK_HZ / 1000;   // 1 ms per digit
    localparam int DEF_BLANK_CYC    = 20;
    localparam int DEF_ALARM_HALF   = SYS_CLK_HZ / 2;      // 0.5 s flash half-period
    localparam int DEF_BUZZ_DIV     = SYS_CLK_HZ / 4000;   // 2 kHz tone

    typedef enum logic {
        PHASE_OFF = 1'b0,
        PHASE_ON  = 1'b1
    } phase_e;

    // One byte per digit, digit 0 in the least significant byte.
    typedef logic [DIGITS-1:0][7:0] frame_t;

    // Active-low one-hot anode pattern for a digit index.
    function automatic logic [5:0] anode_sel(input logic [2:0] idx);
        return ~(6'b00_0001 << idx);
    endfunction

endpackage : seg_scan_driver_pkg
`default_nettype wire

// File: rtl/seg_scan_driver_tick_div.sv
`default_nettype none
// ============================================================================
//  Module      : tick_div
//  Description : Free-running modulo-DIV counter with synchronous clear and
//                enable; emits a one-cycle wrap pulse on the terminal count.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_div #(
    parameter  int DIV = 1000,
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic          wrap,
    output logic [CW-1:0] count
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_term;

    assign at_term = (cnt_q == CW'(DIV - 1));

    // Next count: clear wins, otherwise advance and fold back at the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = at_term ? '0 : cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wrap  = en & ~clr & at_term;
    assign count = cnt_q;

endmodule : tick_div
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_driver
//  Description : Time-multiplexes a six-digit active-low segment frame onto a
//                shared segment bus with per-digit blanking, alarm flashing
//                and a buzzer tone.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int SCAN_DIV   = DEF_SCAN_DIV,
    parameter int BLANK_CYC  = DEF_BLANK_CYC,
    parameter int ALARM_HALF = DEF_ALARM_HALF,
    parameter int BUZZ_DIV   = DEF_BUZZ_DIV
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] seg_in,
    input  logic        alarm,
    output logic [5:0]  an,
    output logic [7:0]  seg,
    output logic        buzz,
    output logic        frame_done
);

    localparam int SCW = $clog2(SCAN_DIV);
    localparam int FCW = $clog2(ALARM_HALF);
    localparam int TCW = $clog2(BUZZ_DIV);

    // ------------------------------------------------------------------
    // Timebases
    // ------------------------------------------------------------------
    logic           slot_wrap;
    logic [SCW-1:0] slot_cnt;
    logic           flash_wrap;
    logic [FCW-1:0] flash_cnt;
    logic           tone_wrap;
    logic [TCW-1:0] tone_cnt;

    tick_div #(.DIV(SCAN_DIV)) u_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .en    (1'b1),
        .wrap  (slot_wrap),
        .count (slot_cnt)
    );

    // Flash and tone counters only run while the alarm is up; holding them
    // at zero while idle means every alarm starts from a clean count.
    tick_div #(.DIV(ALARM_HALF)) u_flash (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (~alarm),
        .en    (alarm),
        .wrap  (flash_wrap),
        .count (flash_cnt)
    );

    tick_div #(.DIV(BUZZ_DIV)) u_tone (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (~alarm),
        .en    (alarm),
        .wrap  (tone_wrap),
        .count (tone_cnt)
    );

    // Counter values of the alarm timebases are not needed, only their wraps.
    logic unused_cnts;
    assign unused_cnts = ^{flash_cnt, tone_cnt};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0] idx_q,   idx_d;
    frame_t     snap_q,  snap_d;
    logic       valid_q, valid_d;
    logic       alarm_q;
    phase_e     phase_q, phase_d;
    logic       tone_q,  tone_d;
    logic [5:0] an_q,    an_d;
    logic [7:0] seg_q,   seg_d;
    logic       buzz_q,  buzz_d;

    logic frame_wrap;
    logic alarm_rise;
    logic show;

    assign frame_wrap = slot_wrap && (idx_q == 3'(DIGITS - 1));
    assign alarm_rise = alarm & ~alarm_q;

    // Digit advance and frame snapshot; seg_in is only sampled at the frame boundary.
    always_comb begin
        idx_d   = idx_q;
        snap_d  = snap_q;
        valid_d = valid_q;
        if (slot_wrap) begin
            idx_d = (idx_q == 3'(DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
        end
        if (frame_wrap) begin
            snap_d  = seg_in;
            valid_d = 1'b1;
        end
    end

    // Flash phase and tone level; idle and alarm onset both restart in the ON phase.
    always_comb begin
        phase_d = phase_q;
        tone_d  = tone_q;
        if (!alarm || alarm_rise) begin
            phase_d = PHASE_ON;
            tone_d  = 1'b0;
        end else begin
            if (flash_wrap) begin
                phase_d = (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
            end
            if (tone_wrap) begin
                tone_d = ~tone_q;
            end
        end
    end

    // Output decode; the live alarm level gates forcing so a drop takes effect next cycle.
    always_comb begin
        show   = valid_q && (slot_cnt >= SCW'(BLANK_CYC));
        an_d   = AN_OFF;
        seg_d  = SEG_OFF;
        buzz_d = alarm && (phase_q == PHASE_ON) && tone_q;
        if (show) begin
            an_d = anode_sel(idx_q);
            if (!(alarm && (phase_q == PHASE_OFF))) begin
                seg_d = snap_q[idx_q];
            end
        end
    end

    // All state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= 3'd0;
            snap_q  <= {DIGITS{SEG_OFF}};
            valid_q <= 1'b0;
            alarm_q <= 1'b0;
            phase_q <= PHASE_ON;
            tone_q  <= 1'b0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            buzz_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            valid_q <= valid_d;
            alarm_q <= alarm;
            phase_q <= phase_d;
            tone_q  <= tone_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            buzz_q  <= buzz_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign buzz       = buzz_q;
    assign frame_done = frame_wrap;

endmodule : seg_scan_driver
`default_nettype wire
